// File: rtl/alu_pkg.sv
// Purpose: shared types and constants for the ALU operand sequencer.
// Contents: entry-stage encoding, ALU op codes, operand field offsets in alu_sw.
// Latency/backpressure: not applicable (declarations only).
package alu_pkg;

  // Entry stage; the encoding is shown directly on the status LEDs.
  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    SHOW     = 2'd3
  } stage_e;

  // Op codes understood by alu_gatelvl.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NAND = 4'd7,
    OP_NOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_GT   = 4'd12,
    OP_LT   = 4'd13,
    OP_EQ   = 4'd14,
    OP_INC  = 4'd15
  } alu_op_e;

  // Field positions inside the 16-bit ALU switch word.
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 4;
  localparam int OP_LSB = 8;
  localparam int FLD_W  = 4;

endpackage

// File: rtl/input_debounce.sv
// Purpose: synchronise one raw board input and debounce it with a stability counter.
// Latency: input stable from edge 0 -> o_db changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; pulses shorter than DEBOUNCE_CYCLES are filtered out.
// Ports: clk, rst_n (async active-low), i_raw (asynchronous input), o_db (debounced level).
module input_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_db;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_db     = r_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Count consecutive cycles where the synced level disagrees with the
  // debounced level; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (w_synced == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_db  <= w_synced;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Purpose: nibble-by-nibble entry of A, B and Op from board switches, presented as a stable ALU word.
// Latency: debounced ENTER edge -> operand register / alu_sw update one edge later.
// Backpressure: none; each debounced press yields one step, CLEAR overrides ENTER.
// Ports: clk, rst_n (async active-low); sw_raw[3:0], btn_enter, btn_clear (raw board inputs);
//        alu_sw[15:0] = {0, op, b, a}; alu_valid (stage==SHOW); stage[1:0]; preview[3:0] (debounced switches).
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw_raw,
  input  logic        btn_enter,
  input  logic        btn_clear,
  output logic [15:0] alu_sw,
  output logic        alu_valid,
  output logic [1:0]  stage,
  output logic [3:0]  preview
);

  logic [3:0] w_preview;
  logic       w_db_enter;
  logic       w_db_clear;
  logic       r_enter_q;
  logic       r_clear_q;
  logic       w_enter_p;
  logic       w_clear_p;

  stage_e     r_stage;
  stage_e     w_stage_nxt;
  logic       w_cap_a;
  logic       w_cap_b;
  logic       w_cap_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_op;
  logic       r_valid;

  for (genvar g = 0; g < 4; g++) begin : g_sw_db
    input_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
      .clk  (clk),
      .rst_n(rst_n),
      .i_raw(sw_raw[g]),
      .o_db (w_preview[g])
    );
  end

  input_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk  (clk),
    .rst_n(rst_n),
    .i_raw(btn_enter),
    .o_db (w_db_enter)
  );

  input_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk  (clk),
    .rst_n(rst_n),
    .i_raw(btn_clear),
    .o_db (w_db_clear)
  );

  // Rising-edge detect: one pulse per debounced press, however long it is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enter_q <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_enter_q <= w_db_enter;
      r_clear_q <= w_db_clear;
    end
  end

  assign w_enter_p = w_db_enter & ~r_enter_q;
  assign w_clear_p = w_db_clear & ~r_clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= ENTER_A;
    end else begin
      r_stage <= w_stage_nxt;
    end
  end

  // CLEAR takes priority so a simultaneous ENTER captures nothing.
  always_comb begin
    w_stage_nxt = r_stage;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_cap_op    = 1'b0;
    if (w_clear_p) begin
      w_stage_nxt = ENTER_A;
    end else if (w_enter_p) begin
      unique case (r_stage)
        ENTER_A: begin
          w_cap_a     = 1'b1;
          w_stage_nxt = ENTER_B;
        end
        ENTER_B: begin
          w_cap_b     = 1'b1;
          w_stage_nxt = ENTER_OP;
        end
        ENTER_OP: begin
          w_cap_op    = 1'b1;
          w_stage_nxt = SHOW;
        end
        SHOW: begin
          w_stage_nxt = ENTER_A;
        end
        default: begin
          w_stage_nxt = ENTER_A;
        end
      endcase
    end
  end

  // Operands change only on their own capture step or on CLEAR, so the
  // ALU never sees the live switch nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_clear_p) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else begin
      if (w_cap_a)  r_a  <= w_preview;
      if (w_cap_b)  r_b  <= w_preview;
      if (w_cap_op) r_op <= w_preview;
    end
  end

  // Registered from the next state so it tracks stage==SHOW without glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_stage_nxt == SHOW);
    end
  end

  always_comb begin
    alu_sw                      = '0;
    alu_sw[A_LSB  +: FLD_W]     = r_a;
    alu_sw[B_LSB  +: FLD_W]     = r_b;
    alu_sw[OP_LSB +: FLD_W]     = r_op;
  end

  assign alu_valid = r_valid;
  assign stage     = r_stage;
  assign preview   = w_preview;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw_raw = 4'h0;
  logic        btn_enter = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] alu_sw;
  logic        alu_valid;
  logic [1:0]  stage;
  logic [3:0]  preview;

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .alu_sw   (alu_sw),
    .alu_valid(alu_valid),
    .stage    (stage),
    .preview  (preview)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what the operator has entered so far.
  int m_a, m_b, m_op, m_stage;
  logic [18:0] last_exp;
  logic [18:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [18:0] mon_prev;

  function automatic logic [18:0] model_tuple();
    logic [15:0] w;
    w = 16'(m_op * 256 + m_b * 16 + m_a);
    return {(m_stage == 3), 2'(m_stage), w};
  endfunction

  // Only visible changes are queued; the monitor pops on each observed change.
  task automatic push_exp();
    logic [18:0] t;
    t = model_tuple();
    if (t != last_exp) begin
      exp_q.push_back(t);
      last_exp = t;
    end
  endtask

  task automatic model_enter(input int v);
    if (m_stage == 0) m_a = v;
    else if (m_stage == 1) m_b = v;
    else if (m_stage == 2) m_op = v;
    m_stage = (m_stage + 1) % 4;
    push_exp();
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
    push_exp();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v, input bit wiggle);
    model_enter(int'(v));
    sw_raw = v;
    cyc(8);
    btn_enter = 1'b1;
    cyc(8);
    // Changing switches after the press has registered must not alter the capture.
    if (wiggle) sw_raw = 4'($urandom);
    btn_enter = 1'b0;
    cyc(8);
  endtask

  task automatic press_clear(input bit with_enter);
    model_clear();
    btn_clear = 1'b1;
    btn_enter = with_enter;
    cyc(8);
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    cyc(8);
  endtask

  task automatic bounce_enter(input logic [3:0] v);
    model_enter(int'(v));
    sw_raw = v;
    cyc(8);
    for (int i = 0; i < 10; i++) begin
      btn_enter = ~btn_enter;
      cyc(2);
    end
    btn_enter = 1'b1;
    cyc(10);
    btn_enter = 1'b0;
    cyc(8);
  endtask

  task automatic pulse_reset();
    m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
    push_exp();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_alu_sw", 32'(alu_sw), 32'h0);
    chk("async_rst_stage", 32'(stage), 32'd0);
    chk("async_rst_valid", 32'(alu_valid), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(8);
  endtask

  // Monitor: every observed output change must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if ({alu_valid, stage, alu_sw} !== mon_prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %h expected no change", {alu_valid, stage, alu_sw});
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          if ({alu_valid, stage, alu_sw} !== e) begin
            bad++;
            $display("FAIL scoreboard: got %h expected %h at %0t", {alu_valid, stage, alu_sw}, e, $time);
          end
        end
        mon_prev = {alu_valid, stage, alu_sw};
      end
    end
  end

  initial begin
    cyc(3);
    chk("reset_alu_sw", 32'(alu_sw), 32'h0);
    chk("reset_valid", 32'(alu_valid), 32'd0);
    chk("reset_stage", 32'(stage), 32'd0);
    chk("reset_preview", 32'(preview), 32'd0);
    m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
    last_exp = model_tuple();
    mon_prev = 19'h0;
    mon_en   = 1'b1;
    rst_n    = 1'b1;

    // Latency: switches and ENTER raised together at edge 0.
    @(posedge clk); #1;
    model_enter(12);
    sw_raw    = 4'hC;
    btn_enter = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 5) chk("lat_preview_e5", 32'(preview), 32'h0);
      if (e == 6) begin
        chk("lat_preview_e6", 32'(preview), 32'hC);
        chk("lat_alu_sw_e6", 32'(alu_sw), 32'h0);
      end
      if (e == 7) begin
        chk("lat_alu_sw_e7", 32'(alu_sw), 32'h000C);
        chk("lat_stage_e7", 32'(stage), 32'd1);
      end
    end
    btn_enter = 1'b0;
    cyc(8);

    // Full entry A=4, B=3, Op=ADD.
    press_clear(1'b0);
    press(4'h4, 1'b0);
    press(4'h3, 1'b1);
    press(4'h0, 1'b0);
    chk("full_alu_sw", 32'(alu_sw), 32'h0034);
    chk("full_valid", 32'(alu_valid), 32'd1);
    chk("full_stage", 32'(stage), 32'd3);

    // SHOW then ENTER keeps operands; new A replaces only the A field.
    press(4'h9, 1'b0);
    chk("show_exit_valid", 32'(alu_valid), 32'd0);
    chk("show_exit_stage", 32'(stage), 32'd0);
    chk("show_exit_alu_sw", 32'(alu_sw), 32'h0034);
    press(4'h6, 1'b0);
    chk("new_a_alu_sw", 32'(alu_sw), 32'h0036);

    // Bounce on ENTER advances exactly one stage.
    bounce_enter(4'h5);
    chk("bounce_stage", 32'(stage), 32'd2);
    chk("bounce_alu_sw", 32'(alu_sw), 32'h0056);

    // CLEAR in ENTER_OP with A=7, B=3, alone and together with ENTER.
    press_clear(1'b0);
    press(4'h7, 1'b0);
    press(4'h3, 1'b0);
    press_clear(1'b1);
    chk("clr_en_alu_sw", 32'(alu_sw), 32'h0);
    chk("clr_en_stage", 32'(stage), 32'd0);
    chk("clr_en_valid", 32'(alu_valid), 32'd0);
    press(4'h7, 1'b0);
    press(4'h3, 1'b0);
    press_clear(1'b0);
    chk("clr_alu_sw", 32'(alu_sw), 32'h0);
    chk("clr_stage", 32'(stage), 32'd0);

    // Reset mid ENTER_B, then entry restarts at A.
    press(4'h5, 1'b0);
    pulse_reset();
    press(4'h2, 1'b0);
    chk("post_rst_alu_sw", 32'(alu_sw), 32'h0002);
    chk("post_rst_stage", 32'(stage), 32'd1);

    // Randomised operator sessions.
    for (int it = 0; it < 50; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) press(4'($urandom), 1'($urandom));
      else if (r == 6) press_clear(1'b0);
      else if (r == 7) press_clear(1'b1);
      else if (r == 8) bounce_enter(4'($urandom));
      else pulse_reset();
    end

    cyc(20);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_alu_sw", 32'(alu_sw), 32'(model_tuple() & 19'hFFFF));
    chk("final_stage", 32'(stage), 32'(m_stage));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
